map_frame_ctrl: RTL and testbench

MAP_FRAME_CTRL -- requirements
Module: map_frame_ctrl

---
 rtl/map_dec_pkg.sv | 13 +
 rtl/map_frame_ctrl.sv | 123 ++++++++++++
 tb/tb_map_frame_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_dec_pkg.sv
// Shared definitions for the MAP decoder frame path: controller state encoding
// and the default frame length that matches the decoder width.
package map_dec_pkg;

    localparam int MAP_FRAME_LEN = 10;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } map_state_t;

endpackage

// File: rtl/map_frame_ctrl.sv
// Frame controller around a combinational MAP decoder: gathers FRAME_LEN hard
// symbol pairs, holds them while the decoder settles, then presents its decisions.
module map_frame_ctrl
    import map_dec_pkg::*;
#(
    parameter int FRAME_LEN   = MAP_FRAME_LEN,
    parameter int DEC_LATENCY = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_y1,
    input  logic                 in_y2,
    output logic [FRAME_LEN-1:0] dec_y1,
    output logic [FRAME_LEN-1:0] dec_y2,
    input  logic [FRAME_LEN-1:0] dec_v,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAME_LEN-1:0] out_bits,
    output logic                 busy,
    output logic [7:0]           frame_cnt
);

    localparam int               IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [7:0]       RUN_LOAD = 8'(DEC_LATENCY);

    generate
        if (DEC_LATENCY < 1 || DEC_LATENCY > 255) begin : g_bad_latency
            $error("map_frame_ctrl: DEC_LATENCY must lie in 1..255");
        end
        if (FRAME_LEN < 1) begin : g_bad_len
            $error("map_frame_ctrl: FRAME_LEN must be at least 1");
        end
    endgenerate

    map_state_t       state;
    map_state_t       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       run_cnt;
    logic             xfer;
    logic             last_sym;
    logic             run_done;
    logic             take;

    always_comb begin
        in_ready  = (state == ST_FILL);
        out_valid = (state == ST_OUT);
        busy      = (state != ST_FILL);
    end

    // flush wins over both handshakes: a symbol offered with it is dropped,
    // and a frame handed over with it is not counted.
    always_comb begin
        xfer     = in_valid & in_ready & ~flush;
        last_sym = xfer & (idx == IDX_LAST);
        run_done = (state == ST_RUN) && (run_cnt == 8'd0);
        take     = out_valid & out_ready & ~flush;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_FILL;
        end else begin
            case (state)
                ST_FILL: if (last_sym)  state_nxt = ST_RUN;
                ST_RUN:  if (run_done)  state_nxt = ST_OUT;
                ST_OUT:  if (out_ready) state_nxt = ST_FILL;
                default:                state_nxt = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // run_cnt is loaded on the last write and counted down to zero, so the
    // decisions are sampled DEC_LATENCY+1 edges after that write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            run_cnt   <= '0;
            dec_y1    <= '0;
            dec_y2    <= '0;
            out_bits  <= '0;
            frame_cnt <= '0;
        end else begin
            if (flush) begin
                idx <= '0;
            end else if (xfer) begin
                idx <= last_sym ? '0 : idx + IDX_W'(1);
            end

            if (xfer) begin
                dec_y1[idx] <= in_y1;
                dec_y2[idx] <= in_y2;
            end

            if (last_sym) begin
                run_cnt <= RUN_LOAD;
            end else if (state == ST_RUN && run_cnt != 8'd0) begin
                run_cnt <= run_cnt - 8'd1;
            end

            if (run_done && !flush) begin
                out_bits <= dec_v;
            end

            if (take) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_map_frame_ctrl.sv
// Directed bench for map_frame_ctrl with a bench-driven decoder output.
module tb_map_frame_ctrl;

    localparam int FL = 10;
    localparam int DL = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_y1 = 1'b0;
    logic          in_y2 = 1'b0;
    logic          out_ready = 1'b0;
    logic [FL-1:0] dec_v = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [FL-1:0] dec_y1;
    logic [FL-1:0] dec_y2;
    logic [FL-1:0] out_bits;
    logic [7:0]    frame_cnt;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    map_frame_ctrl #(.FRAME_LEN(FL), .DEC_LATENCY(DL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_y1(in_y1), .in_y2(in_y2),
        .dec_y1(dec_y1), .dec_y2(dec_y2), .dec_v(dec_v),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // symbol k of the frame is bit k of y1/y2
    task automatic send_frame(input logic [FL-1:0] y1, input logic [FL-1:0] y2);
        int guard;
        for (int k = 0; k < FL; k++) begin
            guard    = 0;
            in_valid = 1'b1;
            in_y1    = y1[k];
            in_y2    = y2[k];
            while (!in_ready && guard < 100) begin
                step();
                guard++;
            end
            n_chk++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL send_ready: in_ready=%b required 1 at symbol %0d", in_ready, k);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    // decoder output is junk until just before the sampling edge, junk again afterwards
    task automatic wait_out(input logic [FL-1:0] good, output int lat);
        lat   = -1;
        dec_v = ~good;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (i == DL) dec_v = good;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        dec_v = ~good;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_chk++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: {in_ready,out_valid,busy}=%b required 100", {in_ready, out_valid, busy});
        end
        n_chk++;
        if (frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: frame_cnt=%0d required 0", frame_cnt);
        end
        n_chk++;
        if ({dec_y1, dec_y2, out_bits} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: dec_y1=%h dec_y2=%h out_bits=%h required 0", dec_y1, dec_y2, out_bits);
        end
    endtask

    task automatic test_basic();
        int lat;
        send_frame(10'h155, 10'h2AA);
        n_chk++;
        if (dec_y1 !== 10'h155 || dec_y2 !== 10'h2AA) begin
            n_fail++;
            $display("FAIL basic_frame: dec_y1=%h dec_y2=%h required 155 2aa", dec_y1, dec_y2);
        end
        n_chk++;
        if ({busy, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_run: {busy,in_ready}=%b required 10", {busy, in_ready});
        end
        wait_out(10'h2AA, lat);
        n_chk++;
        if (lat != DL + 1) begin
            n_fail++;
            $display("FAIL basic_latency: %0d cycles required %0d", lat, DL + 1);
        end
        n_chk++;
        if (out_bits !== 10'h2AA || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_out: out_bits=%h in_ready=%b required 2aa 0", out_bits, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt++;
        n_chk++;
        if (frame_cnt !== exp_cnt || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_handshake: frame_cnt=%0d out_valid=%b in_ready=%b required %0d 0 1",
                     frame_cnt, out_valid, in_ready, exp_cnt);
        end
    endtask

    task automatic test_stall();
        int lat;
        send_frame(10'h3A1, 10'h05E);
        wait_out(10'h1C3, lat);
        n_chk++;
        if (lat != DL + 1) begin
            n_fail++;
            $display("FAIL stall_latency: %0d cycles required %0d", lat, DL + 1);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            n_chk++;
            if ({out_valid, in_ready, out_bits} !== {1'b1, 1'b0, 10'h1C3}) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d out_valid=%b in_ready=%b out_bits=%h required 1 0 1c3",
                         c, out_valid, in_ready, out_bits);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt++;
        n_chk++;
        if (in_ready !== 1'b1 || frame_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL stall_release: in_ready=%b frame_cnt=%0d required 1 %0d", in_ready, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush_fill();
        int lat;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_y1    = 1'b1;
            in_y2    = 1'b1;
            step();
        end
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if ({in_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_fill_state: {in_ready,busy}=%b required 10", {in_ready, busy});
        end
        send_frame(10'h3C4, 10'h0B2);
        n_chk++;
        if (dec_y1 !== 10'h3C4 || dec_y2 !== 10'h0B2) begin
            n_fail++;
            $display("FAIL flush_fill_frame: dec_y1=%h dec_y2=%h required 3c4 0b2", dec_y1, dec_y2);
        end
        wait_out(10'h111, lat);
        n_chk++;
        if (lat != DL + 1 || out_bits !== 10'h111) begin
            n_fail++;
            $display("FAIL flush_fill_out: latency=%0d out_bits=%h required %0d 111", lat, out_bits, DL + 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt++;
        n_chk++;
        if (frame_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL flush_fill_cnt: frame_cnt=%0d required %0d", frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_run();
        send_frame(10'h2F0, 10'h10F);
        for (int c = 0; c < 7; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        n_chk++;
        if ({in_ready, out_valid, busy} !== 3'b100 || frame_cnt !== 8'd0 || dec_y1 !== '0) begin
            n_fail++;
            $display("FAIL reset_run: in_ready=%b out_valid=%b busy=%b frame_cnt=%0d dec_y1=%h required 1 0 0 0 0",
                     in_ready, out_valid, busy, frame_cnt, dec_y1);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_run_stale: cycle %0d out_valid=%b required 0", c, out_valid);
            end
        end
    endtask

    task automatic test_flush_out();
        int lat;
        send_frame(10'h0FF, 10'h300);
        wait_out(10'h3E7, lat);
        n_chk++;
        if (lat != DL + 1) begin
            n_fail++;
            $display("FAIL flush_out_latency: %0d cycles required %0d", lat, DL + 1);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        n_chk++;
        if (frame_cnt !== exp_cnt || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_out: frame_cnt=%0d out_valid=%b in_ready=%b required %0d 0 1",
                     frame_cnt, out_valid, in_ready, exp_cnt);
        end
        n_chk++;
        if (out_bits !== 10'h3E7) begin
            n_fail++;
            $display("FAIL flush_out_bits: out_bits=%h required 3e7", out_bits);
        end
    endtask

    task automatic test_wrap();
        int            lat;
        logic [FL-1:0] good;
        out_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            good = FL'(f) ^ 10'h2A5;
            send_frame(FL'(f * 3 + 1), ~FL'(f));
            wait_out(good, lat);
            n_chk++;
            if (lat != DL + 1 || out_bits !== good) begin
                n_fail++;
                $display("FAIL wrap_frame: frame %0d latency=%0d out_bits=%h required %0d %h",
                         f, lat, out_bits, DL + 1, good);
            end
            step();
            exp_cnt++;
            n_chk++;
            if (frame_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL wrap_cnt: frame %0d frame_cnt=%0d required %0d", f, frame_cnt, exp_cnt);
            end
        end
        out_ready = 1'b0;
        n_chk++;
        if (frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_final: frame_cnt=%0d required 0", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush_fill();
        test_reset_run();
        test_flush_out();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
